// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encodings (shared with
// the decoder), default latencies, FSM state encoding and counter width.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  localparam int MDU_CNT_W        = 4;
  localparam int DEF_MULT_CYCLES  = 5;
  localparam int DEF_DIV_CYCLES   = 10;

  typedef logic [MDU_CNT_W-1:0] mdu_cnt_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator: full 64-bit multiply or divide/remainder for
// the selected MDUOp, plus a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    is_signed = (op == MDU_DIV);
    prod_u    = {32'd0, a} * {32'd0, b};
    prod_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    // Divide on magnitudes so INT_MIN / -1 falls out naturally as 0x80000000 rem 0.
    a_mag     = (is_signed && a[31]) ? (32'd0 - a) : a;
    b_mag     = (is_signed && b[31]) ? (32'd0 - b) : b;
    div_b     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / div_b;
    r_mag     = a_mag % div_b;
    div0      = op[1] && (b == 32'd0);

    case (op)
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      default: begin
        res_lo = (is_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        res_hi = (is_signed && a[31]) ? (32'd0 - r_mag) : r_mag;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO. Optional macro
// MDU_START_BUSY_EN also raises Busy combinationally in the Start cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDUOp,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam mdu_cnt_t MULT_LOAD = mdu_cnt_t'(MULT_CYCLES);
  localparam mdu_cnt_t DIV_LOAD  = mdu_cnt_t'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  mdu_cnt_t    cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_div0;

  mdu_arith u_arith (
    .op     (MDUOp),
    .a      (A),
    .b      (B),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (res_div0)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          div0_d    = res_div0;
          cnt_d     = MDUOp[1] ? DIV_LOAD : MULT_LOAD;
          state_d   = S_RUN;
        end else begin
          if (HIWrite) hi_d = A;
          if (LOWrite) lo_d = A;
        end
      end
      S_RUN: begin
        // Requests arriving here are ignored; only the countdown advances.
        cnt_d = cnt_q - mdu_cnt_t'(1);
        if (cnt_q == mdu_cnt_t'(1)) begin
          if (!div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

`ifdef MDU_START_BUSY_EN
  assign Busy = busy_q | (Start & (state_q == S_IDLE));
`else
  assign Busy = busy_q;
`endif

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table-driven operations with a
// scoreboard queue, plus hand-written ignore/reset/back-to-back sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDUOp;
  logic        HIWrite;
  logic        LOWrite;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDUOp   (MDUOp),
    .HIWrite (HIWrite),
    .LOWrite (LOWrite),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          keep;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t        vecs[12];
  exp_t        sb_q[$];
  int          tests  = 0;
  int          failed = 0;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
`ifdef MDU_START_BUSY_EN
  localparam logic START_BUSY = 1'b1;
`else
  localparam logic START_BUSY = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Drives a one-cycle Start; returns in cycle 1 after the Start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDUOp = op;
    A     = a;
    B     = b;
    #1;
    check("busy_in_start_cycle", {31'd0, Busy}, {31'd0, START_BUSY});
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, output int cnt);
    cnt = start_cnt;
    while (Busy && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input bit keep, input int cyc);
    exp_t e;
    exp_t got;
    int   cnt;
    e.hi  = keep ? model_hi : hi;
    e.lo  = keep ? model_lo : lo;
    e.cyc = cyc;
    sb_q.push_back(e);
    issue(op, a, b);
    wait_done(0, cnt);
    got = sb_q.pop_front();
    check({name, "_busy_cycles"}, 32'(cnt), 32'(got.cyc));
    check({name, "_hi"}, HI, got.hi);
    check({name, "_lo"}, LO, got.lo);
    model_hi = got.hi;
    model_lo = got.lo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 5};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0, 5};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10};
    vecs[3]  = '{MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 10};
    vecs[4]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 5};
    vecs[5]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 5};
    vecs[6]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 10};
    vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 10};
    vecs[8]  = '{MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 10};
    vecs[9]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 10};
    vecs[10] = '{MDU_DIV,   32'd5,        32'd0,        32'd0,        32'd0,        1'b1, 10};
    vecs[11] = '{MDU_MULT,  32'd0,        32'h12345,    32'd0,        32'd0,        1'b0, 5};

    reset = 1'b1; Start = 1'b0; MDUOp = 2'b00; HIWrite = 1'b0; LOWrite = 1'b0;
    A = '0; B = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    model_hi = '0;
    model_lo = '0;

    // Table runs back-to-back: each Start lands in the cycle Busy falls.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].keep, vecs[i].cyc);
    end

    // mthi / mtlo, then divide by zero leaves them untouched.
    HIWrite = 1'b1; A = 32'h1234; step(); HIWrite = 1'b0;
    check("mthi_hi", HI, 32'h1234);
    LOWrite = 1'b1; A = 32'h5678; step(); LOWrite = 1'b0;
    check("mtlo_lo", LO, 32'h5678);
    check("mtlo_hi_kept", HI, 32'h1234);
    model_hi = 32'h1234; model_lo = 32'h5678;
    step();
    run_op("divu_by_zero", MDU_DIVU, 32'd99, 32'd0, 32'd0, 32'd0, 1'b1, 10);

    HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hCAFE; step(); HIWrite = 1'b0; LOWrite = 1'b0;
    check("mthi_mtlo_hi", HI, 32'hCAFE);
    check("mthi_mtlo_lo", LO, 32'hCAFE);

    // Requests during RUN are ignored.
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    step();
    HIWrite = 1'b1; A = 32'hDEAD;
    step();
    HIWrite = 1'b0;
    Start = 1'b1; MDUOp = MDU_DIV; A = 32'd7; B = 32'd2;
    check("run_ignore_hiwrite", HI, 32'hCAFE);
    step();
    Start = 1'b0;
    wait_done(3, cnt);
    check("run_ignore_cycles", 32'(cnt), 32'd5);
    check("run_ignore_hi", HI, 32'hFFFFFFFF);
    check("run_ignore_lo", LO, 32'hFFFFFFFA);
    step();
    check("run_ignore_no_div", {31'd0, Busy}, 32'd0);

    // Reset in the middle of a divide.
    issue(MDU_DIV, 32'd100, 32'd7);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midop_reset_busy", {31'd0, Busy}, 32'd0);
    check("midop_reset_hi", HI, 32'd0);
    check("midop_reset_lo", LO, 32'd0);
    repeat (12) step();
    check("midop_no_commit_hi", HI, 32'd0);
    check("midop_no_commit_lo", LO, 32'd0);
    model_hi = '0; model_lo = '0;

    // Back-to-back after a completed op.
    run_op("again_mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 5);
    run_op("b2b_multu", MDU_MULTU, 32'h10000, 32'h10000, 32'd1, 32'd0, 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
